// File: rtl/apb_req_arbiter_if.sv
// APB bus bundle between apb_req_arbiter (master side) and the slave fabric.
interface apb_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters,
// with an ACCESS-phase timeout so a hung slave cannot lock the bus.
module apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           err,
  apb_req_arbiter_if.master              apb
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   psel_q, penable_q;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [NUM_REQ-1:0]     eligible;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  int                     cand;
  logic                   complete;

  // A requester being acked this cycle is masked so it cannot win again immediately.
  always_comb begin
    eligible   = req & ~ack_q;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    ack_d    = '0;
    rdata_d  = '0;
    err_d    = 1'b0;
    complete = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = SETUP;
          grant_d  = pick_idx;
          pwrite_d = req_write[pick_idx];
          paddr_d  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d = req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      SETUP: begin
        state_d = ACCESS;
      end

      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // PREADY wins over a timeout landing in the same cycle.
        if (apb.PREADY) begin
          complete = 1'b1;
          err_d    = apb.PSLVERR;
          rdata_d  = pwrite_q ? '0 : apb.PRDATA;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          complete = 1'b1;
          err_d    = 1'b1;
        end
        if (complete) begin
          state_d = IDLE;
          cnt_d   = '0;
          ack_d   = NUM_REQ'(1) << grant_q;
          rr_d    = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus controls are registered straight from the next state so they line up with it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      psel_q    <= (state_d != IDLE);
      penable_q <= (state_d == ACCESS);
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed vector table, multi-cycle
// corner sequences, and random traffic against a transaction-level model.
module tb_apb_req_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int NVEC           = 7;

  logic                          PCLK = 1'b0;
  logic                          PRESETn;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          err;

  apb_req_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) apb ();

  apb_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .err(err), .apb(apb)
  );

  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_mis = 0;

  // Slave model: raises PREADY on ACCESS cycle number wait_cfg+1.
  int          wait_cfg   = 0;
  logic [7:0]  prdata_cfg = 8'h00;
  logic        err_cfg    = 1'b0;
  int          slv_cnt    = 0;

  always @(negedge PCLK) begin
    if (apb.PSEL && apb.PENABLE) begin
      slv_cnt    = slv_cnt + 1;
      apb.PREADY = (slv_cnt > wait_cfg);
    end else begin
      slv_cnt    = 0;
      apb.PREADY = 1'b0;
    end
  end
  assign apb.PRDATA  = prdata_cfg;
  assign apb.PSLVERR = err_cfg;

  typedef struct {
    int         idx;
    logic       write;
    logic [31:0] addr;
    logic [7:0] wdata;
    int         wait_cycles;
    logic [7:0] prdata;
    logic       pslverr;
    logic [3:0] exp_ack;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_acc;
    int         exp_lat;
  } vec_t;

  typedef struct {
    bit         done;
    int         lat;
    int         acc;
    logic [3:0] ack;
    logic [7:0] rdata;
    logic       err;
    bit         bus_ok;
    logic       psel_at_ack;
    logic [3:0] ack_after;
  } obs_t;

  vec_t vecs[NVEC];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output obs_t o);
    o.done = 0; o.lat = 0; o.acc = 0; o.ack = '0; o.rdata = '0; o.err = 1'b0;
    o.bus_ok = 1; o.psel_at_ack = 1'b0; o.ack_after = '0;
    @(negedge PCLK);
    wait_cfg   = v.wait_cycles;
    prdata_cfg = v.prdata;
    err_cfg    = v.pslverr;
    req_write[v.idx] = v.write;
    req_addr[v.idx*ADDR_WIDTH +: ADDR_WIDTH] = v.addr;
    req_wdata[v.idx*DATA_WIDTH +: DATA_WIDTH] = v.wdata;
    req[v.idx] = 1'b1;
    for (int c = 1; c <= 60 && !o.done; c++) begin
      @(negedge PCLK);
      if (apb.PSEL && apb.PENABLE) begin
        o.acc++;
        if (apb.PADDR !== v.addr || apb.PWRITE !== v.write || apb.PWDATA !== v.wdata)
          o.bus_ok = 0;
      end
      if (ack != '0) begin
        o.done = 1; o.lat = c; o.ack = ack; o.rdata = rdata; o.err = err;
        o.psel_at_ack = apb.PSEL;
        req[v.idx] = 1'b0;
      end
    end
    req[v.idx] = 1'b0;
    @(negedge PCLK);
    o.ack_after = ack;
  endtask

  task automatic doReset();
    @(negedge PCLK);
    PRESETn = 1'b0;
    req     = '0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  function automatic int pickRR(input logic [3:0] elig, input int start);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (elig[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Transaction-level reference: grant winner, access count and results per transfer.
  task automatic runRandom(input int cycles);
    bit          pending[NUM_REQ];
    logic [31:0] f_addr[NUM_REQ];
    logic [7:0]  f_wdata[NUM_REQ];
    logic        f_write[NUM_REQ];
    int          rr_m = 0;
    int          winner = -1;
    int          acc_m = 0;
    int          wait_m = 0;
    logic [7:0]  prd_m = '0;
    logic        perr_m = 1'b0;
    logic [3:0]  req_before = req;
    logic [3:0]  ack_before = ack;
    bit          idle_before = !apb.PSEL;
    logic [3:0]  elig;
    logic [31:0] rnd;
    int          w, exp_acc, left;
    bit          tmo;
    for (int i = 0; i < NUM_REQ; i++) begin
      pending[i] = 0; f_addr[i] = '0; f_wdata[i] = '0; f_write[i] = 1'b0;
    end
    for (int c = 0; c < cycles + 400; c++) begin
      @(negedge PCLK);
      elig = req_before & ~ack_before;
      if (idle_before) begin
        if (elig != '0) begin
          w = pickRR(elig, rr_m);
          checkOutput("rnd_setup", {apb.PSEL, apb.PENABLE}, 2'b10);
          checkOutput("rnd_grant", {apb.PWRITE, apb.PADDR, apb.PWDATA},
                      {f_write[w], f_addr[w], f_wdata[w]});
          winner = w;
          acc_m  = 0;
          wait_m = ($urandom_range(7) == 0) ? 20 : int'($urandom_range(3));
          prd_m  = 8'($urandom_range(255));
          perr_m = ($urandom_range(3) == 0);
          wait_cfg = wait_m; prdata_cfg = prd_m; err_cfg = perr_m;
        end else begin
          checkOutput("rnd_idle", apb.PSEL, 1'b0);
        end
      end
      if (winner >= 0 && apb.PSEL && apb.PENABLE) acc_m++;
      if (ack != '0) begin
        if (winner < 0) begin
          checkOutput("rnd_spurious_ack", ack, 4'b0000);
        end else begin
          tmo     = (wait_m >= TIMEOUT_CYCLES);
          exp_acc = tmo ? TIMEOUT_CYCLES : wait_m + 1;
          checkOutput("rnd_ack", ack, 4'b0001 << winner);
          checkOutput("rnd_acc", acc_m, exp_acc);
          checkOutput("rnd_err", err, tmo ? 1'b1 : perr_m);
          checkOutput("rnd_rdata", rdata, (tmo || f_write[winner]) ? 8'h00 : prd_m);
          checkOutput("rnd_psel_off", apb.PSEL, 1'b0);
          pending[winner] = 0;
          req[winner]     = 1'b0;
          rr_m   = (winner + 1) % NUM_REQ;
          winner = -1;
        end
      end
      if (c < cycles) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!pending[i] && $urandom_range(2) == 0) begin
            rnd        = $urandom;
            pending[i] = 1;
            f_write[i] = rnd[0];
            f_addr[i]  = {rnd[31:3], 3'(i)};
            f_wdata[i] = 8'($urandom_range(255));
            req_write[i] = f_write[i];
            req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = f_addr[i];
            req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = f_wdata[i];
            req[i] = 1'b1;
          end
        end
      end
      req_before  = req;
      ack_before  = ack;
      idle_before = !apb.PSEL;
      left = (winner >= 0) ? 1 : 0;
      for (int i = 0; i < NUM_REQ; i++) left += pending[i] ? 1 : 0;
      if (c >= cycles && left == 0) break;
    end
    left = (winner >= 0) ? 1 : 0;
    for (int i = 0; i < NUM_REQ; i++) left += pending[i] ? 1 : 0;
    checkOutput("rnd_drained", left, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    obs_t o;
    int   k, last, seen;

    //                idx wr addr          wdata wait prdata err  ack      rdata err acc lat
    vecs[0] = '{0, 1'b1, 32'h0000_1000, 8'hA5, 0,   8'h77, 1'b0, 4'b0001, 8'h00, 1'b0, 1,  3};
    vecs[1] = '{2, 1'b0, 32'h0000_0020, 8'h00, 3,   8'h3C, 1'b0, 4'b0100, 8'h3C, 1'b0, 4,  6};
    vecs[2] = '{1, 1'b1, 32'h0000_2004, 8'h5A, 0,   8'h66, 1'b1, 4'b0010, 8'h00, 1'b1, 1,  3};
    vecs[3] = '{3, 1'b0, 32'hFFFF_FFFC, 8'h00, 1,   8'hC3, 1'b1, 4'b1000, 8'hC3, 1'b1, 2,  4};
    vecs[4] = '{0, 1'b0, 32'h0000_0040, 8'h00, 100, 8'h99, 1'b0, 4'b0001, 8'h00, 1'b1, 16, 18};
    vecs[5] = '{1, 1'b0, 32'h0000_0044, 8'h00, 15,  8'h81, 1'b0, 4'b0010, 8'h81, 1'b0, 16, 18};
    vecs[6] = '{2, 1'b1, 32'h0000_0048, 8'hFF, 14,  8'h00, 1'b0, 4'b0100, 8'h00, 1'b0, 15, 17};

    PRESETn = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    #2 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    checkOutput("reset_ctrl", {apb.PSEL, apb.PENABLE, apb.PWRITE}, 3'b000);
    checkOutput("reset_bus", {apb.PADDR, apb.PWDATA}, 40'h0);
    checkOutput("reset_resp", {ack, rdata, err}, 13'h0);
    PRESETn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], o);
      checkOutput($sformatf("v%0d_done", i), o.done, 1'b1);
      checkOutput($sformatf("v%0d_ack", i), o.ack, vecs[i].exp_ack);
      checkOutput($sformatf("v%0d_rdata", i), o.rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d_err", i), o.err, vecs[i].exp_err);
      checkOutput($sformatf("v%0d_access_cycles", i), o.acc, vecs[i].exp_acc);
      checkOutput($sformatf("v%0d_latency", i), o.lat, vecs[i].exp_lat);
      checkOutput($sformatf("v%0d_bus_stable", i), o.bus_ok, 1'b1);
      checkOutput($sformatf("v%0d_psel_at_ack", i), o.psel_at_ack, 1'b0);
      checkOutput($sformatf("v%0d_ack_one_cycle", i), o.ack_after, 4'b0000);
    end

    // Round robin with all four requesters held high for two full rounds.
    doReset();
    wait_cfg = 0; err_cfg = 1'b0; prdata_cfg = 8'h11;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_write[i] = 1'b1;
      req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = 32'(32'h100 + i);
      req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = 8'(8'h10 + i);
    end
    req = 4'hF;
    k = 0; last = 0;
    for (int c = 1; c <= 60 && k < 8; c++) begin
      @(negedge PCLK);
      if (ack != '0) begin
        checkOutput("rr_order", ack, 4'b0001 << (k % NUM_REQ));
        if (k > 0) checkOutput("rr_spacing", c - last, 3);
        last = c;
        if (k >= 4) req[k % NUM_REQ] = 1'b0;
        k++;
      end
    end
    checkOutput("rr_count", k, 8);

    // Single requester holding req across its ack must skip one IDLE cycle.
    @(negedge PCLK);
    req_write[1] = 1'b0;
    req_addr[ADDR_WIDTH +: ADDR_WIDTH] = 32'h2222_0001;
    prdata_cfg = 8'h5C;
    req[1] = 1'b1;
    k = 0; last = 0;
    for (int c = 1; c <= 40 && k < 2; c++) begin
      @(negedge PCLK);
      if (ack != '0) begin
        checkOutput("rereq_ack", ack, 4'b0010);
        checkOutput("rereq_rdata", rdata, 8'h5C);
        if (k == 1) begin
          checkOutput("rereq_spacing", c - last, 4);
          req[1] = 1'b0;
        end
        last = c;
        k++;
        if (k == 1) begin
          @(negedge PCLK);
          c++;
          checkOutput("rereq_masked", {apb.PSEL, ack}, 5'b00000);
        end
      end
    end
    checkOutput("rereq_count", k, 2);

    // Reset pulsed mid-ACCESS clears outputs at once and suppresses the ack.
    @(negedge PCLK);
    wait_cfg = 100; err_cfg = 1'b0;
    req_write[2] = 1'b1;
    req_addr[2*ADDR_WIDTH +: ADDR_WIDTH]  = 32'hDEAD_BEE0;
    req_wdata[2*DATA_WIDTH +: DATA_WIDTH] = 8'h3C;
    req[2] = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge PCLK);
      if (apb.PENABLE) seen = 1;
    end
    checkOutput("mid_reached_access", seen, 1);
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    checkOutput("mid_rst_ctrl", {apb.PSEL, apb.PENABLE, apb.PWRITE}, 3'b000);
    checkOutput("mid_rst_bus", {apb.PADDR, apb.PWDATA}, 40'h0);
    checkOutput("mid_rst_resp", {ack, rdata, err}, 13'h0);
    @(negedge PCLK);
    req = '0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge PCLK);
      if (ack != '0 || apb.PSEL) seen = 1;
    end
    checkOutput("mid_rst_no_ack", seen, 0);

    doReset();
    runRandom(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one APB master port between NUM_REQ local requesters using round-robin arbitration.
- Runs the APB IDLE/SETUP/ACCESS sequence for the winning requester and returns read data, error status and a completion ack.
- Sits between on-chip clients (DMA, CPU bridge, debug) and the APB slave fabric.
- Includes an ACCESS-phase timeout so that a hung slave cannot lock the bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 8, APB data width.
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles before an abort; 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock.
- PRESETn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transfer request, held high until its ack.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing.
- ack  out  NUM_REQ  one-cycle completion pulse to the served requester.
- rdata  out  DATA_WIDTH  read data, valid while ack is high.
- err  out  1  error flag (PSLVERR or timeout), valid while ack is high.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  in  1  APB slave response.

Behaviour:
- Reset is PRESETn, asynchronous, active-low; clock is PCLK.
- Reset values: state IDLE; PSEL=PENABLE=PWRITE=0; PADDR=0; PWDATA=0; ack=0; rdata=0; err=0; RR pointer=0; timeout counter=0.
- All outputs are registered.
- Reset asserted mid-transfer aborts immediately. No ack is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - The eligible set is req masked by the current ack, so a requester being acked this cycle is not re-granted in the same cycle.
  - If the eligible set is non-empty, pick the first set bit scanning from the RR pointer upward with wrap-around.
  - Latch the grant index, req_addr, req_wdata and req_write into PADDR/PWDATA/PWRITE.
  - Move to SETUP.
- SETUP: PSEL=1, PENABLE=0; unconditionally move to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWDATA and PWRITE stay stable for the whole transfer.
  - The timeout counter increments each ACCESS cycle.
  - If PREADY=1: the transfer completes.
  - Otherwise, if TIMEOUT_CYCLES!=0 and this is ACCESS cycle number TIMEOUT_CYCLES (counting from 1): the transfer aborts.
  - Otherwise: stay in ACCESS.
- Completion (normal or timeout), on the next clock edge:
  - state IDLE; PSEL=PENABLE=0.
  - ack[grant]=1 for exactly one cycle.
  - RR pointer = (grant+1) mod NUM_REQ.
  - Timeout counter cleared.
- Normal completion results:
  - err = PSLVERR.
  - rdata = PRDATA for a read; rdata = 0 for a write.
- Timeout results: err=1, rdata=0.
- PREADY=1 in the same cycle the timeout would fire counts as normal completion.
- A transfer always passes through at least one IDLE cycle. Back-to-back transfers take a minimum of 3 cycles each.
- Latency: req seen high in IDLE at edge N gives SETUP at N+1, ACCESS at N+2, and ack at edge N+3 when PREADY is immediately 1.
- PADDR/PWDATA/PWRITE keep their last values in IDLE and change only on a grant.
- Requester contract: a requester keeps req and its fields stable from assertion until ack, and may drop or re-raise req on the cycle after ack.
  - Dropping req before ack is illegal.
  - Once a requester is granted, the arbiter ignores its inputs until completion.

Test Plan:
1. Single write: req=4'b0001, addr=0x1000, wdata=0xA5, PREADY=1 in the first ACCESS cycle -> one SETUP cycle then one ACCESS cycle with PADDR=0x1000, PWDATA=0xA5, PWRITE=1; ack=4'b0001 exactly 3 cycles after req is sampled; err=0.
2. Read with waits: requester 2 reads 0x20, PREADY low for 3 ACCESS cycles, PRDATA=0x3C -> PENABLE high for 4 cycles; ack[2]=1 with rdata=0x3C.
3. Round-robin: all four requesters held high continuously -> grant order 0,1,2,3,0; each ack separated by one IDLE cycle; no requester is served twice before the others.
4. Re-request masking: only requester 1 active, and it re-raises req the cycle after ack -> one IDLE cycle with no grant, then requester 1 is granted again; no double ack.
5. Slave error: PSLVERR=1 with PREADY=1 on a write -> ack pulse with err=1, rdata=0.
6. Timeout and reset: PREADY held 0 with TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then ack with err=1 and PSEL=0. Separately, PRESETn pulsed low during ACCESS -> all outputs 0 asynchronously and no ack.
